// File: rtl/reset_debounce.sv
// reset_debounce
// ---------------------------------------------------------------------------
// Board-level reset conditioner. It turns a raw, bouncy, asynchronous reset
// button into a clean, stretched, active-high reset request for the
// downstream clock/reset generator. It also holds reset high for a fixed
// power-on period after RESET deasserts, and provides a debounced button
// level and a one-cycle strobe for each accepted press.
//
// Ports:
//   CLK          in   board clock, the only clock in this block
//   RESET        in   asynchronous active-high block reset
//   btn          in   raw board button, asynchronous to CLK, may bounce
//   rst_out      out  registered active-high reset request
//   btn_clean    out  registered debounced button level (1 = pressed)
//   press_pulse  out  registered one-cycle strobe on an accepted press
//   state        out  current FSM state (POR=0, RUN=1, DB_PRESS=2,
//                     HOLD=3, DB_RELEASE=4) for debug
// ---------------------------------------------------------------------------
module reset_debounce #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int STRETCH_CYCLES  = 64,
   parameter int POR_CYCLES      = 256,
   parameter int BTN_ACTIVE_LOW  = 1
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       btn,
   output logic       rst_out,
   output logic       btn_clean,
   output logic       press_pulse,
   output logic [2:0] state
);

   // Counter is sized for the largest terminal count it has to reach.
   localparam int MAX_AB = (POR_CYCLES > STRETCH_CYCLES) ? POR_CYCLES : STRETCH_CYCLES;
   localparam int MAX_C  = (MAX_AB > DEBOUNCE_CYCLES) ? MAX_AB : DEBOUNCE_CYCLES;
   localparam int CNT_W  = $clog2(MAX_C + 1);

   localparam logic [CNT_W-1:0] POR_LAST = CNT_W'(POR_CYCLES - 1);
   localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] ST_LAST  = CNT_W'(STRETCH_CYCLES - 1);

   // Raw level the button shows when it is NOT pressed.
   localparam logic BTN_IDLE = (BTN_ACTIVE_LOW != 0);

   typedef enum logic [2:0] {
      ST_POR        = 3'd0,
      ST_RUN        = 3'd1,
      ST_DB_PRESS   = 3'd2,
      ST_HOLD       = 3'd3,
      ST_DB_RELEASE = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              sync1_q, sync1_d;
   logic              sync2_q, sync2_d;
   logic              rst_out_q, rst_out_d;
   logic              btn_clean_q, btn_clean_d;
   logic              press_pulse_q, press_pulse_d;
   logic              p;

   // Synchronized button, normalised so that 1 always means pressed.
   assign p = sync2_q ^ BTN_IDLE;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q       <= ST_POR;
         cnt_q         <= '0;
         sync1_q       <= BTN_IDLE;
         sync2_q       <= BTN_IDLE;
         rst_out_q     <= 1'b1;
         btn_clean_q   <= 1'b0;
         press_pulse_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         rst_out_q     <= rst_out_d;
         btn_clean_q   <= btn_clean_d;
         press_pulse_q <= press_pulse_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      sync1_d       = btn;
      sync2_d       = sync1_q;
      btn_clean_d   = btn_clean_q;
      press_pulse_d = 1'b0;

      case (state_q)
         ST_POR: begin
            // Button is ignored until the power-on hold has expired.
            if (cnt_q == POR_LAST) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_RUN: begin
            if (p) begin
               state_d = ST_DB_PRESS;
               cnt_d   = '0;
            end
         end

         ST_DB_PRESS: begin
            if (!p) begin
               // Glitch: drop back without touching any output.
               state_d = ST_RUN;
               cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
               state_d       = ST_HOLD;
               cnt_d         = '0;
               btn_clean_d   = 1'b1;
               press_pulse_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_HOLD: begin
            // The stretch window ignores the button entirely; once it has
            // elapsed the counter sits saturated until a release is seen.
            if (cnt_q < ST_LAST) begin
               cnt_d = cnt_q + 1'b1;
            end else if (!p) begin
               state_d = ST_DB_RELEASE;
               cnt_d   = '0;
            end
         end

         ST_DB_RELEASE: begin
            if (p) begin
               // Release bounce: back to HOLD with the stretch already spent,
               // so no fresh stretch and no new press strobe.
               state_d = ST_HOLD;
               cnt_d   = ST_LAST;
            end else if (cnt_q == DB_LAST) begin
               state_d     = ST_RUN;
               cnt_d       = '0;
               btn_clean_d = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d     = ST_POR;
            cnt_d       = '0;
            btn_clean_d = 1'b0;
         end
      endcase

      // Decoded from the next state so rst_out moves on the same edge as
      // the state change that causes it.
      rst_out_d = (state_d == ST_POR) || (state_d == ST_HOLD) ||
                  (state_d == ST_DB_RELEASE);
   end

   assign rst_out     = rst_out_q;
   assign btn_clean   = btn_clean_q;
   assign press_pulse = press_pulse_q;
   assign state       = state_q;

endmodule

// File: tb/tb_reset_debounce.sv
module tb_reset_debounce;

  localparam int D = 4;
  localparam int S = 8;
  localparam int P = 16;

  logic       clk;
  logic       rst;
  logic       btn;
  logic       rst_out;
  logic       btn_clean;
  logic       press_pulse;
  logic [2:0] state;

  int total;
  int bad;
  bit chk_en;

  reset_debounce #(
    .DEBOUNCE_CYCLES(D),
    .STRETCH_CYCLES (S),
    .POR_CYCLES     (P),
    .BTN_ACTIVE_LOW (1)
  ) dut (
    .CLK        (clk),
    .RESET      (rst),
    .btn        (btn),
    .rst_out    (rst_out),
    .btn_clean  (btn_clean),
    .press_pulse(press_pulse),
    .state      (state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Described in terms of run lengths: how many POR edges remain, whether a
  // press is currently held, how long the consecutive pressed / released
  // sample runs are, and how long ago the press was accepted.
  int por_left;
  bit held;
  int press_run;
  int release_run;
  int hold_age;
  bit m_pulse;
  bit s1, s2;
  bit pr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 = 1'b1; s2 = 1'b1;
      por_left = P; held = 1'b0;
      press_run = 0; release_run = 0; hold_age = 0; m_pulse = 1'b0;
    end else begin
      pr = !s2;          // button pressed = low, seen two edges late
      s2 = s1;
      s1 = btn;
      m_pulse = 1'b0;
      if (por_left > 0) begin
        por_left--;
      end else if (!held) begin
        if (pr) begin
          press_run++;
          if (press_run == D + 1) begin
            held = 1'b1; m_pulse = 1'b1; press_run = 0; hold_age = 0;
          end
        end else begin
          press_run = 0;
        end
      end else if (release_run == 0) begin
        if (hold_age < S - 1) hold_age++;
        else if (!pr) release_run = 1;
      end else begin
        if (pr) begin
          release_run = 0;   // stretch already spent; hold_age stays at S-1
        end else begin
          release_run++;
          if (release_run == D + 1) begin
            held = 1'b0; release_run = 0;
          end
        end
      end
    end
  end

  function automatic int exp_state();
    if (por_left > 0) return 0;
    if (!held) return (press_run == 0) ? 1 : 2;
    return (release_run == 0) ? 3 : 4;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("mdl_state", 32'(state), 32'(exp_state()));
      check("mdl_rst_out", 32'(rst_out), 32'((por_left > 0) || held));
      check("mdl_btn_clean", 32'(btn_clean), 32'(held));
      check("mdl_press_pulse", 32'(press_pulse), 32'(m_pulse));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic por_sequence(input string tag);
    for (int i = 1; i <= 20; i++) begin
      cyc(1);
      check({tag, "_rst_out"}, 32'(rst_out), (i < P) ? 32'd1 : 32'd0);
      check({tag, "_state"}, 32'(state), (i < P) ? 32'd0 : 32'd1);
      check({tag, "_pulse"}, 32'(press_pulse), 32'd0);
    end
  endtask

  logic [23:0] bounce_pat;

  // ---------------- stimulus ----------------
  initial begin
    total = 0; bad = 0; chk_en = 1'b0;
    rst = 1'b0; btn = 1'b1;
    bounce_pat = 24'b0000_0101_1000_0000_0011_0110;
    #1 rst = 1'b1;
    #1 chk_en = 1'b1;

    // Power-on reset
    cyc(3);
    check("reset_state", 32'(state), 32'd0);
    check("reset_rst_out", 32'(rst_out), 32'd1);
    check("reset_btn_clean", 32'(btn_clean), 32'd0);
    rst = 1'b0;
    por_sequence("por");
    check("por_btn_clean", 32'(btn_clean), 32'd0);

    // Glitch: three low cycles are not enough
    btn = 1'b0;
    cyc(3);
    check("glitch_in_db", 32'(state), 32'd2);
    check("glitch_rst_out", 32'(rst_out), 32'd0);
    btn = 1'b1;
    cyc(3);
    check("glitch_back_run", 32'(state), 32'd1);
    check("glitch_clean", 32'(btn_clean), 32'd0);
    cyc(5);

    // Long press: 40 low cycles
    btn = 1'b0;
    cyc(6);
    check("long_pre_pulse", 32'(press_pulse), 32'd0);
    check("long_pre_state", 32'(state), 32'd2);
    cyc(1);
    check("long_pulse", 32'(press_pulse), 32'd1);
    check("long_rst_rise", 32'(rst_out), 32'd1);
    check("long_clean_rise", 32'(btn_clean), 32'd1);
    cyc(1);
    check("long_pulse_once", 32'(press_pulse), 32'd0);
    cyc(32);
    check("long_held_rst", 32'(rst_out), 32'd1);
    check("long_held_clean", 32'(btn_clean), 32'd1);
    btn = 1'b1;
    cyc(6);
    check("long_rel_state", 32'(state), 32'd4);
    check("long_rel_rst", 32'(rst_out), 32'd1);
    cyc(1);
    check("long_rst_fall", 32'(rst_out), 32'd0);
    check("long_clean_fall", 32'(btn_clean), 32'd0);
    cyc(5);

    // Short press: 6 low cycles, stretch governs the release
    btn = 1'b0;
    cyc(6);
    btn = 1'b1;
    cyc(1);
    check("short_hold", 32'(state), 32'd3);
    cyc(7);
    check("short_hold_end", 32'(state), 32'd3);
    cyc(1);
    check("short_db_rel", 32'(state), 32'd4);
    cyc(3);
    check("short_rel_rst", 32'(rst_out), 32'd1);
    cyc(1);
    check("short_run", 32'(state), 32'd1);
    check("short_rst_fall", 32'(rst_out), 32'd0);
    cyc(5);

    // Release bounce
    btn = 1'b0;
    cyc(6);
    btn = 1'b1;
    cyc(9);
    check("bounce_db_rel", 32'(state), 32'd4);
    btn = 1'b0;
    cyc(1);
    btn = 1'b1;
    cyc(2);
    check("bounce_rehold", 32'(state), 32'd3);
    check("bounce_no_pulse", 32'(press_pulse), 32'd0);
    cyc(1);
    check("bounce_db_rel2", 32'(state), 32'd4);
    cyc(3);
    check("bounce_still_rel", 32'(state), 32'd4);
    cyc(1);
    check("bounce_run", 32'(state), 32'd1);
    check("bounce_rst_fall", 32'(rst_out), 32'd0);
    cyc(5);

    // Irregular bouncy pattern, checked by the model only
    for (int i = 0; i < 24; i++) begin
      btn = bounce_pat[i];
      cyc(1);
    end
    btn = 1'b1;
    cyc(30);

    // A couple of random-length presses, checked by the model only
    for (int k = 0; k < 3; k++) begin
      btn = 1'b0;
      cyc($urandom_range(2, 12));
      btn = 1'b1;
      cyc($urandom_range(25, 35));
    end

    // Asynchronous reset in the middle of HOLD
    btn = 1'b0;
    cyc(9);
    check("async_pre_hold", 32'(state), 32'd3);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_state", 32'(state), 32'd0);
    check("async_rst_out", 32'(rst_out), 32'd1);
    check("async_clean", 32'(btn_clean), 32'd0);
    check("async_pulse", 32'(press_pulse), 32'd0);
    cyc(1);
    btn = 1'b1;
    cyc(2);
    rst = 1'b0;
    por_sequence("por2");
    cyc(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
